// File: rtl/seven_segment_decoder_pkg.sv
// seven_seg_pkg: glyph codes, anode/segment constants and anode classification shared by the display driver, decoder and benches
package seven_seg_pkg;
    typedef logic [4:0] glyph_t;
    localparam glyph_t GLYPH_0     = 5'h00;
    localparam glyph_t GLYPH_1     = 5'h01;
    localparam glyph_t GLYPH_2     = 5'h02;
    localparam glyph_t GLYPH_3     = 5'h03;
    localparam glyph_t GLYPH_4     = 5'h04;
    localparam glyph_t GLYPH_5     = 5'h05;
    localparam glyph_t GLYPH_6     = 5'h06;
    localparam glyph_t GLYPH_7     = 5'h07;
    localparam glyph_t GLYPH_8     = 5'h08;
    localparam glyph_t GLYPH_9     = 5'h09;
    localparam glyph_t GLYPH_A     = 5'h0A;
    localparam glyph_t GLYPH_B     = 5'h0B;
    localparam glyph_t GLYPH_C     = 5'h0C;
    localparam glyph_t GLYPH_D     = 5'h0D;
    localparam glyph_t GLYPH_E     = 5'h0E;
    localparam glyph_t GLYPH_F     = 5'h0F;
    localparam glyph_t GLYPH_N     = 5'h10;
    localparam glyph_t GLYPH_BLANK = 5'h11;
    localparam glyph_t GLYPH_BAD   = 5'h1F;
    localparam logic [3:0] AN_IDLE = 4'hF;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_N     = 7'b1101010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    typedef enum logic [1:0] {AN_CLS_VALID, AN_CLS_IDLE, AN_CLS_ILLEGAL} an_class_t;
    // exactly one active-low anode selects a digit; all-high is a blanked scan slot
    function automatic an_class_t an_classify(input logic [3:0] an);
        return an == AN_IDLE ? AN_CLS_IDLE : $onehot(~an) ? AN_CLS_VALID : AN_CLS_ILLEGAL;
    endfunction
endpackage

// File: rtl/seven_segment_decoder_glyph.sv
// seg_glyph_decode: combinational active-low 7-segment pattern to glyph code lookup
//   seg_i   in  7  active-low segments, seg_i[6]=a .. seg_i[0]=g
//   glyph_o out 5  glyph code, GLYPH_BAD for unrecognised patterns
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output glyph_t     glyph_o
);
    always_comb begin
        case (seg_i)
            SEG_0:     glyph_o = GLYPH_0;
            SEG_1:     glyph_o = GLYPH_1;
            SEG_2:     glyph_o = GLYPH_2;
            SEG_3:     glyph_o = GLYPH_3;
            SEG_4:     glyph_o = GLYPH_4;
            SEG_5:     glyph_o = GLYPH_5;
            SEG_6:     glyph_o = GLYPH_6;
            SEG_7:     glyph_o = GLYPH_7;
            SEG_8:     glyph_o = GLYPH_8;
            SEG_9:     glyph_o = GLYPH_9;
            SEG_A:     glyph_o = GLYPH_A;
            SEG_B:     glyph_o = GLYPH_B;
            SEG_C:     glyph_o = GLYPH_C;
            SEG_D:     glyph_o = GLYPH_D;
            SEG_E:     glyph_o = GLYPH_E;
            SEG_F:     glyph_o = GLYPH_F;
            SEG_N:     glyph_o = GLYPH_N;
            SEG_BLANK: glyph_o = GLYPH_BLANK;
            default:   glyph_o = GLYPH_BAD;
        endcase
    end
endmodule

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: monitors a scanned 4-digit seven-segment bus and reassembles the displayed frame
//   clk         in  1   system clock
//   rst         in  1   synchronous active-low reset
//   seg_bus     in  11  {an[3:0], seg[6:0]}, both active-low, an[3] leftmost
//   glyphs      out 20  last complete frame {d3,d2,d1,d0}
//   frame_valid out 1   pulse when glyphs updates
//   done_match  out 1   glyphs spell "dOnE"
//   an_err      out 1   pulse on entry into an illegal anode pattern
//   digit_seen  out 4   digits captured in the frame being assembled
module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] seg_bus,
    output logic [19:0] glyphs,
    output logic        frame_valid,
    output logic        done_match,
    output logic        an_err,
    output logic [3:0]  digit_seen
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    logic [10:0] bus_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    glyph_t [3:0] slot_q, slot_d;
    logic [19:0] glyphs_q, glyphs_d;
    logic [3:0] seen_q, seen_d;
    logic fv_q, done_q, done_d, err_q;
    an_class_t cls, prev_cls;
    glyph_t glyph;
    logic same, capture, illegal_edge, frame_done;
    logic [1:0] idx;
    seg_glyph_decode u_dec (.seg_i(bus_q[6:0]), .glyph_o(glyph));
    assign cls          = an_classify(bus_q[10:7]);
    assign prev_cls     = an_classify(prev_q[10:7]);
    assign same         = bus_q == prev_q;
    // the 0 in the anode field marks the slot; only meaningful when cls is VALID
    assign idx          = {~bus_q[10] | ~bus_q[9], ~bus_q[10] | ~bus_q[8]};
    // fires only on the step into saturation, so a long dwell captures once
    assign capture      = cls == AN_CLS_VALID && same && cnt_q == CW'(STABLE_CYCLES - 1);
    assign illegal_edge = cls == AN_CLS_ILLEGAL && prev_cls != AN_CLS_ILLEGAL;
    assign frame_done   = seen_q == 4'hF;
    always_comb begin
        cnt_d    = cls != AN_CLS_VALID ? '0 : !same ? CW'(1) : cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1);
        slot_d   = slot_q;
        seen_d   = seen_q;
        glyphs_d = glyphs_q;
        done_d   = done_q;
        if (frame_done) begin
            glyphs_d = slot_q;
            done_d   = slot_q == {GLYPH_D, GLYPH_0, GLYPH_N, GLYPH_E};
            seen_d   = '0;
        end
        if (capture) begin
            slot_d[idx] = glyph;
            seen_d[idx] = 1'b1;
        end
        if (illegal_edge) seen_d = '0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_q    <= 11'h7FF;
            prev_q   <= 11'h7FF;
            cnt_q    <= '0;
            slot_q   <= {4{GLYPH_BLANK}};
            glyphs_q <= {4{GLYPH_BLANK}};
            seen_q   <= '0;
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            bus_q    <= seg_bus;
            prev_q   <= bus_q;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            glyphs_q <= glyphs_d;
            seen_q   <= seen_d;
            fv_q     <= frame_done;
            done_q   <= done_d;
            err_q    <= illegal_edge;
        end
    end
    assign glyphs      = glyphs_q;
    assign frame_valid = fv_q;
    assign done_match  = done_q;
    assign an_err      = err_q;
    assign digit_seen  = seen_q;
endmodule
